// File: rtl/flit_source_pkg.sv
// Shared definitions for the CALF flit injector and the matching sink/checker.
// Holds FSM state encoding, control-word field offsets and the control-word packing macro.
`timescale 1ns/1ps
package flit_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_BACKOFF = 2'd2
  } state_t;

  localparam int FLD_VALID    = 0;
  localparam int FLD_DEST_LSB = 1;

  function automatic int fld_src_lsb(input int dest_w);
    return dest_w + 1;
  endfunction

  function automatic int fld_seq_lsb(input int dest_w, input int src_w);
    return dest_w + src_w + 1;
  endfunction

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

`ifndef FLIT_CTRL
// Control word {seq, src, dest, valid}; arguments must already be sized to their field widths.
`define FLIT_CTRL(seq, src, dest) {(seq), (src), (dest), 1'b1}
`endif

// File: rtl/flit_source_fifo.sv
// Single-clock request FIFO (DEPTH entries, power of two) with full/empty/count.
// Push is ignored when full and pop is ignored when empty.
`timescale 1ns/1ps
module flit_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/flit_source.sv
// Per-port flit injector: buffers requests, stamps source ID and sequence number,
// and drives one registered flit onto the router link whenever the slot is free.
`timescale 1ns/1ps
module flit_source
  import flit_source_pkg::*;
#(
  parameter int DEST_W = 4,
  parameter int SRC_W  = 4,
  parameter int SEQ_W  = 8,
  parameter int DW     = 32,
  parameter int CW     = 1 + DEST_W + SRC_W + SEQ_W,
  parameter int DEPTH  = 4,
  parameter int GAP    = 0,
  parameter int SRC_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DEST_W-1:0] req_dest,
  input  logic [DW-1:0]     req_data,
  input  logic              slot_free,
  output logic [CW-1:0]     port_co,
  output logic [DW-1:0]     port_do,
  output logic [15:0]       inj_count,
  output logic [15:0]       stall_count,
  output state_t            dbg_state
);

  localparam int FW = DEST_W + DW;
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_gap;
  logic [SEQ_W-1:0]  r_seq;
  logic [CW-1:0]     r_port_co;
  logic [DW-1:0]     r_port_do;
  logic [15:0]       r_inj_count;
  logic [15:0]       r_stall_count;

  logic [FW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic              w_push;
  logic              w_inject;
  logic              w_stall;
  logic              w_will_empty;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_inject  = (r_state == ST_ARMED) && !w_empty && slot_free;
  assign w_stall   = (r_state == ST_ARMED) && !w_empty && !slot_free;

  // FIFO occupancy after the current edge is zero.
  assign w_will_empty = !w_push &&
                        ((w_count == '0) || ((w_count == (AW+1)'(1)) && w_inject));

  flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({req_dest, req_data}),
    .i_pop   (w_inject),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_inject) begin
          if (GAP > 0)           w_state_nxt = ST_BACKOFF;
          else if (w_will_empty) w_state_nxt = ST_IDLE;
        end
      end
      ST_BACKOFF: begin
        if (r_gap <= GW'(1)) w_state_nxt = w_will_empty ? ST_IDLE : ST_ARMED;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_gap         <= '0;
      r_seq         <= '0;
      r_port_co     <= '0;
      r_port_do     <= '0;
      r_inj_count   <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_inject)         r_gap <= GW'(GAP);
      else if (r_gap != '0) r_gap <= r_gap - 1'b1;

      // The link carries all zeros in every cycle that does not hold a fresh flit.
      if (w_inject) begin
        r_port_co <= `FLIT_CTRL(r_seq, SRC_W'(SRC_ID), w_head[FW-1:DW]);
        r_port_do <= w_head[DW-1:0];
        r_seq     <= r_seq + 1'b1;
        if (r_inj_count != CNT_MAX) r_inj_count <= r_inj_count + 1'b1;
      end else begin
        r_port_co <= '0;
        r_port_do <= '0;
      end

      if (w_stall && (r_stall_count != CNT_MAX)) r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign port_co     = r_port_co;
  assign port_do     = r_port_do;
  assign inj_count   = r_inj_count;
  assign stall_count = r_stall_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_flit_source.sv
// Directed bench for flit_source: two instances (GAP=0/SRC_ID=2 and GAP=2/SRC_ID=3)
// with a per-instance expected-flit queue checked whenever a valid flit appears on the link.
`timescale 1ns/1ps
module tb_flit_source;
  import flit_source_pkg::*;

  localparam int DEST_W  = 4;
  localparam int SRC_W   = 4;
  localparam int SEQ_W   = 8;
  localparam int DW      = 32;
  localparam int CW      = 1 + DEST_W + SRC_W + SEQ_W;
  localparam int FW      = CW + DW;
  localparam int SEQ_LSB = fld_seq_lsb(DEST_W, SRC_W);
  localparam logic [SRC_W-1:0] SRC_A = 4'd2;
  localparam logic [SRC_W-1:0] SRC_B = 4'd3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic              a_req_valid, b_req_valid;
  logic              a_req_ready, b_req_ready;
  logic [DEST_W-1:0] a_req_dest,  b_req_dest;
  logic [DW-1:0]     a_req_data,  b_req_data;
  logic              a_slot_free, b_slot_free;
  logic [CW-1:0]     a_port_co,   b_port_co;
  logic [DW-1:0]     a_port_do,   b_port_do;
  logic [15:0]       a_inj,       b_inj;
  logic [15:0]       a_stall,     b_stall;
  state_t            a_state,     b_state;

  flit_source #(.GAP(0), .SRC_ID(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_dest(a_req_dest), .req_data(a_req_data), .slot_free(a_slot_free),
    .port_co(a_port_co), .port_do(a_port_do), .inj_count(a_inj),
    .stall_count(a_stall), .dbg_state(a_state)
  );

  flit_source #(.GAP(2), .SRC_ID(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_dest(b_req_dest), .req_data(b_req_data), .slot_free(b_slot_free),
    .port_co(b_port_co), .port_do(b_port_do), .inj_count(b_inj),
    .stall_count(b_stall), .dbg_state(b_state)
  );

  // scoreboard
  int               n_vec = 0;
  int               n_err = 0;
  logic [FW-1:0]    exp_a_q[$];
  logic [FW-1:0]    exp_b_q[$];
  int               vcyc_a_q[$];
  int               vcyc_b_q[$];
  logic [SEQ_W-1:0] seq_log_a[$];
  logic [SEQ_W-1:0] seq_a = '0;
  logic [SEQ_W-1:0] seq_b = '0;
  logic [FW-1:0]    e_a, e_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_port_co[FLD_VALID]) begin
      vcyc_a_q.push_back(cyc);
      seq_log_a.push_back(a_port_co[CW-1:SEQ_LSB]);
      if (exp_a_q.size() == 0) check("a_unexpected_flit", 64'(a_port_co), 64'd0);
      else begin
        e_a = exp_a_q.pop_front();
        check("a_flit", 64'({a_port_co, a_port_do}), 64'(e_a));
      end
    end
    if (rst_n && b_port_co[FLD_VALID]) begin
      vcyc_b_q.push_back(cyc);
      if (exp_b_q.size() == 0) check("b_unexpected_flit", 64'(b_port_co), 64'd0);
      else begin
        e_b = exp_b_q.pop_front();
        check("b_flit", 64'({b_port_co, b_port_do}), 64'(e_b));
      end
    end
  end

  // driver tasks (called at posedge+1, return at the following posedge+1)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel_b, input logic [DEST_W-1:0] d, input logic [DW-1:0] x,
                      output bit acc);
    if (!sel_b) begin
      a_req_valid = 1'b1; a_req_dest = d; a_req_data = x;
      acc = a_req_ready;
      if (acc) begin exp_a_q.push_back({seq_a, SRC_A, d, 1'b1, x}); seq_a++; end
    end else begin
      b_req_valid = 1'b1; b_req_dest = d; b_req_data = x;
      acc = b_req_ready;
      if (acc) begin exp_b_q.push_back({seq_b, SRC_B, d, 1'b1, x}); seq_b++; end
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic push_rand(input bit sel_b, output bit acc);
    push(sel_b, 4'($urandom_range(0, 15)), $urandom(), acc);
  endtask

  task automatic clear_model();
    exp_a_q.delete(); exp_b_q.delete();
    seq_a = '0; seq_b = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [15:0] s0;
    a_req_valid = 0; a_req_dest = '0; a_req_data = '0; a_slot_free = 0;
    b_req_valid = 0; b_req_dest = '0; b_req_data = '0; b_slot_free = 0;

    // reset state
    tick(2);
    check("rst_co", 64'(a_port_co), 64'd0);
    check("rst_do", 64'(a_port_do), 64'd0);
    check("rst_ready", 64'(a_req_ready), 64'd1);
    check("rst_inj", 64'(a_inj), 64'd0);
    check("rst_stall", 64'(a_stall), 64'd0);
    check("rst_state", 64'(a_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick(1);

    // single flit, injected one cycle after acceptance, held one cycle
    a_slot_free = 1'b1;
    push(0, 4'd5, 32'hCAFE0001, acc);
    check("single_acc", 64'(acc), 64'd1);
    tick(1);
    check("single_co", 64'(a_port_co), 64'h4B);
    check("single_do", 64'(a_port_do), 64'hCAFE0001);
    tick(1);
    check("single_one_cycle", 64'(a_port_co), 64'd0);
    check("single_inj", 64'(a_inj), 64'd1);

    // asynchronous reset with 3 flits queued
    a_slot_free = 1'b0;
    repeat (3) push_rand(0, acc);
    rst_n = 1'b0;
    #1;
    check("midrst_co", 64'(a_port_co), 64'd0);
    check("midrst_do", 64'(a_port_do), 64'd0);
    check("midrst_ready", 64'(a_req_ready), 64'd1);
    check("midrst_inj", 64'(a_inj), 64'd0);
    check("midrst_stall", 64'(a_stall), 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_slot_free = 1'b1;
    tick(6);
    check("midrst_no_inject", 64'(a_inj), 64'd0);

    // fill FIFO while blocked, then drain as a back-to-back burst with seq 0..3
    a_slot_free = 1'b0;
    vcyc_a_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_rand(0, acc);
      check("full_acc", 64'(acc), 64'd1);
    end
    check("full_ready", 64'(a_req_ready), 64'd0);
    s0 = a_stall;
    push(0, 4'd7, 32'hDEAD0005, acc);
    check("full_reject", 64'(acc), 64'd0);
    tick(2);
    check("stall_inc", 64'(a_stall), 64'(s0 + 16'd3));
    a_slot_free = 1'b1;
    tick(6);
    check("burst_inj", 64'(a_inj), 64'd4);
    check("burst_cnt", 64'(vcyc_a_q.size()), 64'd4);
    check("burst_span", 64'(vcyc_a_q[3] - vcyc_a_q[0]), 64'd3);
    check("burst_stall_hold", 64'(a_stall), 64'(s0 + 16'd3));

    // push on the same edge as an inject
    a_slot_free = 1'b0;
    vcyc_a_q.delete();
    push_rand(0, acc);
    a_slot_free = 1'b1;
    push_rand(0, acc);
    check("pp_acc", 64'(acc), 64'd1);
    check("pp_count", 64'(u_a.u_fifo.o_count), 64'd1);
    tick(3);
    check("pp_cnt", 64'(vcyc_a_q.size()), 64'd2);
    check("pp_consec", 64'(vcyc_a_q[1] - vcyc_a_q[0]), 64'd1);

    // GAP=2 spacing on instance b
    b_slot_free = 1'b0;
    vcyc_b_q.delete();
    repeat (3) push_rand(1, acc);
    s0 = b_stall;
    b_slot_free = 1'b1;
    tick(12);
    check("gap_cnt", 64'(vcyc_b_q.size()), 64'd3);
    check("gap_1", 64'(vcyc_b_q[1] - vcyc_b_q[0]), 64'd3);
    check("gap_2", 64'(vcyc_b_q[2] - vcyc_b_q[0]), 64'd6);
    check("gap_stall_hold", 64'(b_stall), 64'(s0));
    check("gap_inj", 64'(b_inj), 64'd3);

    // sequence wrap over 257 flits
    rst_n = 1'b0;
    #1;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq_log_a.delete();
    a_slot_free = 1'b1;
    for (int i = 0; i < 257; i++) push_rand(0, acc);
    tick(3);
    check("wrap_inj", 64'(a_inj), 64'd257);
    check("wrap_len", 64'(seq_log_a.size()), 64'd257);
    check("wrap_seq255", 64'(seq_log_a[254]), 64'd254);
    check("wrap_seq256", 64'(seq_log_a[255]), 64'd255);
    check("wrap_seq257", 64'(seq_log_a[256]), 64'd0);

    check("a_drained", 64'(exp_a_q.size()), 64'd0);
    check("b_drained", 64'(exp_b_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
